mem_copy_dma: RTL

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_copy_dma.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared memory-port types and the chunk-sizing helpers used by the copy engine.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } mem_width_t;

  // Largest access that fits in the bytes still to copy; alignment is irrelevant.
  function automatic mem_width_t chunk_width(input logic [31:0] remaining);
    if (remaining >= 32'd4) begin
      return WORD;
    end else if (remaining >= 32'd2) begin
      return HALFWORD;
    end
    return BYTE;
  endfunction

  function automatic logic [2:0] width_bytes(input mem_width_t w);
    case (w)
      BYTE:     return 3'd1;
      HALFWORD: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Forward memory-to-memory copy engine: one read cycle then one write cycle per
// chunk, chunk width shrinking from WORD to BYTE as the tail gets short.
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_i,
  input  logic [AddrWidth-1:0] dst_i,
  input  logic [AddrWidth:0]   len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output mem_width_t           mem_width_o,
  output logic                 mem_sign_extend_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i
);

  localparam int CntW = AddrWidth + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [CntW-1:0]      rem_q, rem_d;
  logic                 done_q, done_d;

  mem_width_t           chunk_w;
  logic [2:0]           chunk_n;

  assign chunk_w = chunk_width(32'(rem_q));
  assign chunk_n = width_bytes(chunk_w);

  assign done_o            = done_q;
  assign mem_sign_extend_o = 1'b0;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    busy_o      = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = WORD;
    mem_we_o    = 1'b0;
    mem_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_i;
          dst_d = dst_i;
          rem_d = len_i;
          // A zero-length request completes immediately without touching memory.
          if (len_i != '0) begin
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        busy_o      = 1'b1;
        mem_addr_o  = src_q;
        mem_width_o = chunk_w;
        state_d     = WR;
      end
      WR: begin
        busy_o      = 1'b1;
        mem_addr_o  = dst_q;
        mem_width_o = chunk_w;
        mem_we_o    = 1'b1;
        // Read data from the previous RD cycle is forwarded straight to the write port.
        mem_data_o  = mem_data_i;
        src_d       = src_q + AddrWidth'(chunk_n);
        dst_d       = dst_q + AddrWidth'(chunk_n);
        rem_d       = rem_q - CntW'(chunk_n);
        if (rem_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule
